// File: rtl/lzd64_seq.sv
// lzd64_seq: sequential 64-bit leading-zero detector.
//
// One 32-bit leading-zero unit (lzd_32bits) is time-shared between the upper
// and lower halves of a registered operand. The upper half is examined first;
// the lower half is only examined when the upper half is all zeros, so the
// result appears two cycles after accept for a nonzero upper half and three
// cycles otherwise. Handshakes are valid/ready on both sides, and the block
// holds at most one operation at a time.
//
// Optional feature: define LZD64_SEQ_NORM_EN to add the out_norm port, which
// carries the operand left-shifted by the leading-zero count (0 for an
// all-zero operand). Without the macro there is no out_norm port and no
// shifter.

// Leading-zero count of a 32-bit word. p is meaningful only when v=1.
module lzd_32bits (
  input  logic [31:0] a,
  output logic [4:0]  p,
  output logic        v
);

  // Scan from LSB to MSB so the highest set bit writes p last and wins.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this
    // block purely combinational; without it a latch would be inferred.
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) begin
        // NOTE: blocking '=' inside always_comb so later loop iterations see
        // and override earlier ones; sequential blocks use '<=' instead.
        p = 5'(31 - i);
      end
    end
  end

  assign v = |a;

endmodule

module lzd64_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_cnt,
  output logic        out_zero,
  output logic        busy
`ifdef LZD64_SEQ_NORM_EN
  ,
  output logic [63:0] out_norm
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic [63:0] operand_q, operand_d;
  logic [6:0]  cnt_q,     cnt_d;
  logic        zero_q,    zero_d;

  logic [31:0] lzd_in;
  logic [4:0]  lzd_p;
  logic        lzd_v;
  logic        accept;

  // The single shared unit: upper half in IDLE/HI/DONE, lower half in LO.
  assign lzd_in = (state_q == S_LO) ? operand_q[31:0] : operand_q[63:32];

  lzd_32bits u_lzd (
    .a (lzd_in),
    .p (lzd_p),
    .v (lzd_v)
  );

  // Flush blocks acceptance so in_valid is ignored while it is asserted.
  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_cnt   = cnt_q;
  assign out_zero  = zero_q;

  // Next-state and datapath: flush overrides every transition; results are
  // captured into registers so the LZD never drives the outputs directly.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            operand_d = in_src;
            state_d   = S_HI;
          end
        end
        S_HI: begin
          if (lzd_v) begin
            cnt_d   = {2'b00, lzd_p};
            zero_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_LO;
          end
        end
        S_LO: begin
          if (lzd_v) begin
            cnt_d  = 7'd32 + {2'b00, lzd_p};
            zero_d = 1'b0;
          end else begin
            cnt_d  = 7'd64;
            zero_d = 1'b1;
          end
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
    end
  end

`ifdef LZD64_SEQ_NORM_EN
  logic [63:0] norm_q, norm_d;
  logic        enter_done;

  assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

  // Normalized operand captured alongside the count; a shift by 64 yields 0.
  always_comb begin
    norm_d = norm_q;
    if (enter_done) begin
      norm_d = operand_q << cnt_d;
    end
  end

  // Normalized-operand register, held with out_cnt until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      norm_q <= '0;
    end else begin
      norm_q <= norm_d;
    end
  end

  assign out_norm = norm_q;
`endif

endmodule

// File: tb/tb_lzd64_seq.sv
// Directed self-checking bench for lzd64_seq. Inputs are driven and outputs
// sampled 1 ns after each rising edge. Define LZD64_SEQ_NORM_EN for both the
// bench and the RTL to also check out_norm.
module tb_lzd64_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_src;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_cnt;
  logic        out_zero;
  logic        busy;
`ifdef LZD64_SEQ_NORM_EN
  logic [63:0] out_norm;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lzd64_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_src    (in_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero),
    .busy      (busy)
`ifdef LZD64_SEQ_NORM_EN
    ,
    .out_norm  (out_norm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept an operand, check latency and the result, then retire it.
  task automatic run_op(input string tag, input logic [63:0] src, input logic [6:0] exp_cnt,
                        input logic exp_zero, input int lat, input logic [63:0] exp_norm);
    in_src   = src;
    in_valid = 1'b1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_src   = '0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    for (int k = 1; k < lat; k++) begin
      check({tag, " early out_valid"}, 64'(out_valid), 64'd0);
      step();
    end
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " out_cnt"},   64'(out_cnt),   64'(exp_cnt));
    check({tag, " out_zero"},  64'(out_zero),  64'(exp_zero));
`ifdef LZD64_SEQ_NORM_EN
    check({tag, " out_norm"},  out_norm,       exp_norm);
`else
    if (exp_norm === 64'hx) $display("note: %s norm", tag);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " retired"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_src    = '0;
    out_ready = 1'b0;
    #12;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy",      64'(busy),      64'd0);
    check("rst out_cnt",   64'(out_cnt),   64'd0);
    check("rst out_zero",  64'(out_zero),  64'd0);
`ifdef LZD64_SEQ_NORM_EN
    check("rst out_norm",  out_norm,       64'd0);
`endif
    rst_n = 1'b1;
    step();
    check("post-rst in_ready", 64'(in_ready), 64'd1);

    run_op("msb",   64'h8000_0000_0000_0000, 7'd0,  1'b0, 2, 64'h8000_0000_0000_0000);
    run_op("lsb",   64'h0000_0000_0000_0001, 7'd63, 1'b0, 3, 64'h8000_0000_0000_0000);
    run_op("zero",  64'h0000_0000_0000_0000, 7'd64, 1'b1, 3, 64'h0000_0000_0000_0000);
    run_op("bit16", 64'h0000_0000_0001_0000, 7'd47, 1'b0, 3, 64'h8000_0000_0000_0000);
    run_op("byte6", 64'h00F0_0000_0000_1234, 7'd8,  1'b0, 2, 64'hF000_0000_0012_3400);

    // Backpressure: result holds, no accept, then back-to-back accept.
    in_src   = 64'h0000_0001_0000_0000;
    in_valid = 1'b1;
    step();
    in_src = 64'h4000_0000_0000_0000;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp out_cnt",   64'(out_cnt),   64'd31);
      check("bp in_ready",  64'(in_ready),  64'd0);
      step();
    end
`ifdef LZD64_SEQ_NORM_EN
    check("bp out_norm", out_norm, 64'h8000_0000_0000_0000);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("b2b idle out_valid", 64'(out_valid), 64'd0);
    check("b2b in_ready",       64'(in_ready),  64'd1);
    step();
    in_valid = 1'b0;
    check("b2b accepted busy", 64'(busy), 64'd1);
    step();
    check("b2b out_valid", 64'(out_valid), 64'd1);
    check("b2b out_cnt",   64'(out_cnt),   64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush while in HI.
    in_src   = 64'h0000_0000_0000_0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    check("flush in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    check("flush-hi busy",      64'(busy),      64'd0);
    check("flush-hi out_valid", 64'(out_valid), 64'd0);
    step();
    step();
    check("flush-hi no result", 64'(out_valid), 64'd0);

    // Flush while in DONE.
    run_op("pre", 64'h0000_0000_0000_0002, 7'd62, 1'b0, 3, 64'h8000_0000_0000_0000);
    in_src   = 64'h0000_0000_0000_0003;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("flush-done reached", 64'(out_valid), 64'd1);
    check("flush-done out_cnt", 64'(out_cnt),   64'd62);
    flush = 1'b1;
    step();
    check("flush-done out_valid", 64'(out_valid), 64'd0);
    check("flush-done busy",      64'(busy),      64'd0);

    // in_valid ignored while flush is high.
    in_src   = 64'h8000_0000_0000_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush ignores in_valid", 64'(busy), 64'd0);

    // Reset pulsed while in LO.
    in_src   = 64'h0000_0000_0000_0005;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("lo busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst-lo busy",      64'(busy),      64'd0);
    check("rst-lo out_valid", 64'(out_valid), 64'd0);
    check("rst-lo out_cnt",   64'(out_cnt),   64'd0);
    check("rst-lo out_zero",  64'(out_zero),  64'd0);
`ifdef LZD64_SEQ_NORM_EN
    check("rst-lo out_norm",  out_norm,       64'd0);
`endif
    #4;
    rst_n = 1'b1;
    step();
    check("rst-lo in_ready",  64'(in_ready),  64'd1);
    step();
    check("rst-lo no result", 64'(out_valid), 64'd0);

    run_op("recover", 64'h0000_0000_8000_0000, 7'd32, 1'b0, 3, 64'h8000_0000_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzd64_seq.md
LZD64_SEQ -- requirements
Module: lzd64_seq

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 64 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 in_src  input  64  operand; bit 63 is the MSB.
REQ-008 out_valid  output  1  result held.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_cnt  output  7  leading-zero count, range 0..64.
REQ-011 out_zero  output  1  operand was all zeros.
REQ-012 busy  output  1  state is not IDLE.
REQ-013 out_norm  output  64  normalized operand; present only when LZD64_SEQ_NORM_EN is defined.

Function
REQ-014 The block SHALL instantiate exactly one lzd_32bits and time-share it between the upper and lower operand halves.
- The shared unit's p output is the leading-zero count of its 32-bit input (0..31).
- The shared unit's v output is 1 when that input is nonzero.
REQ-015 FSM states SHALL be IDLE, HI, LO and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE and flush=0.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 Accept (in_valid & in_ready) SHALL register in_src into an operand register and move IDLE->HI.
REQ-019 In HI, the LZD input SHALL be operand[63:32].
- If v=1: register cnt={0,0,p} and zero=0, then go to DONE.
- If v=0: go to LO.
REQ-020 In LO, the LZD input SHALL be operand[31:0].
- If v=1: register cnt=32+p and zero=0.
- If v=0: register cnt=64 and zero=1.
- In both cases, go to DONE.
REQ-021 In DONE, out_cnt and out_zero SHALL hold stable until out_valid & out_ready, after which the state SHALL go to IDLE.
REQ-022 Latency from the accept edge to out_valid=1 SHALL be:
- 2 cycles when operand[63:32]!=0;
- 3 cycles otherwise.
REQ-023 The block SHALL hold at most one operation; a new accept SHALL occur no earlier than the cycle after the DONE->IDLE transition.
REQ-024 flush=1 SHALL force the next state to IDLE from any state, with priority over every other transition.
REQ-025 A result SHALL count as delivered if out_valid & out_ready occur in the same cycle as flush.
REQ-026 in_valid SHALL be ignored while flush=1.
REQ-027 out_cnt and out_zero SHALL be registered outputs; the LZD outputs SHALL never drive them combinationally.

Reset
REQ-028 rst_n=0 SHALL immediately set:
- state=IDLE;
- out_valid=0, busy=0;
- out_cnt=0, out_zero=0;
- the operand register to 0;
- out_norm to 0 when present.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no result produced.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 With LZD64_SEQ_NORM_EN defined, the block SHALL add port out_norm.
- out_norm is registered on entry to DONE as operand << cnt, which is 0 for cnt=64.
- out_norm holds with out_cnt.
REQ-032 Without LZD64_SEQ_NORM_EN, the block SHALL have no out_norm port and no shifter logic; all other behaviour SHALL be identical.

Verification
REQ-033 in_src=0x8000_0000_0000_0000 -> out_cnt=0, out_zero=0, out_valid 2 cycles after accept (out_norm equal to in_src if enabled).
REQ-034 in_src=0x0000_0000_0000_0001 -> out_cnt=63, out_zero=0, out_valid 3 cycles after accept (out_norm=0x8000_0000_0000_0000 if enabled).
REQ-035 in_src=0 -> out_cnt=64, out_zero=1, 3-cycle latency (out_norm=0 if enabled).
REQ-036 in_src=0x0000_0001_0000_0000 with out_ready=0 for 5 cycles -> out_cnt=31 holds stable, in_ready=0 throughout; with out_ready=1 -> IDLE next cycle, and a back-to-back in_valid is accepted that cycle.
REQ-037 flush=1 in HI, and separately in DONE -> IDLE next cycle, out_valid=0, no result; rst_n pulsed low in LO -> all outputs 0 immediately.
